dds_sweep_ctrl: RTL
===================

# dds_sweep_ctrl

Frequency-sweep scheduler for the phase-accumulator DDS core. It accepts a sweep descriptor over a valid/ready handshake: start FCW, stop FCW, step and dwell. It then drives the core's frequency control word through a stepped linear sweep, up or down, in single-shot or looping mode. It sits between the control/register logic and the DDS core's FCW and accumulator-clear inputs. The DDS core takes FCW from this block instead of its hard-coded reset value.

## Interface
Parameters:
- FCW_W, 24, width of FCW, start, stop and step
- DWELL_W, 16, width of dwell count
- FCW_RESET, 24'd16384, FCW value after reset

Ports:
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- cfg_valid  in  1  descriptor valid
- cfg_ready  out  1  descriptor accepted when cfg_valid && cfg_ready at a rising edge
- cfg_start_fcw  in  FCW_W  first FCW of sweep
- cfg_stop_fcw  in  FCW_W  last FCW of sweep; direction is up if stop >= start, else down
- cfg_step  in  FCW_W  FCW increment magnitude per step
- cfg_dwell  in  DWELL_W  extra cycles each FCW is held (hold time = dwell+1)
- cfg_loop  in  1  0: single sweep; 1: restart from start after stop
- abort  in  1  terminate sweep
- fcw  out  FCW_W  registered FCW to DDS core
- phase_clr  out  1  registered one-cycle pulse, clears DDS accumulator
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse, sweep completed normally

## Operation
- States: IDLE, DWELL.
- cfg_ready = (state==IDLE) && !abort. This is combinational from state and abort.
- **IDLE, on accept:**
  - Latch the descriptor and direction.
  - fcw <= start, phase_clr <= 1, cnt <= cfg_dwell, busy <= 1.
  - Go to DWELL.
- **DWELL, cnt != 0:** cnt decrements; fcw holds.
- **DWELL, cnt == 0, end condition** (fcw == stop, or step == 0):
  - With loop: fcw <= start, phase_clr <= 1, cnt reloaded; stay in DWELL.
  - Without loop: go to IDLE, busy <= 0, done <= 1; fcw holds the last value.
- **DWELL, cnt == 0, otherwise:** fcw <= next, cnt reloaded.
- **Next-FCW arithmetic:** computed in FCW_W+1 bits.
  - Up: next = min(fcw+step, stop).
  - Down: next = max(fcw-step, stop), with an underflow check on the borrow bit.
  - The result is clamped to stop, never wraps, and stop is always emitted exactly once per pass.
- **start == stop:** a single value is held dwell+1 cycles, then the end condition applies.
- **abort:**
  - Highest priority in every state.
  - Next state is IDLE, busy <= 0, no done pulse, no phase_clr.
  - fcw holds its current value.
  - abort in IDLE blocks acceptance.
- **cfg_valid while busy:** ignored; cfg_ready is 0.

## Timing
- **Reset values:** fcw=FCW_RESET, phase_clr=0, busy=0, done=0, state=IDLE, cnt=0. cfg_ready=1 when abort=0.
- **Accept latency:** accept at edge N. From edge N, fcw=start, phase_clr=1 and busy=1. phase_clr falls at edge N+1.
- **Hold time:** each FCW value is held exactly dwell+1 cycles; updates are back-to-back with no gap cycles.
- **Completion:** done is high for the first IDLE cycle, coincident with busy=0 and cfg_ready=1. A new descriptor may be accepted in that same cycle.
- **Loop restart:** phase_clr is coincident with the fcw=start update.
- **Reset mid-sweep:** all outputs take their reset values at the next edge, with no done pulse.

## Structure
- Package dds_pkg holds:
  - the state enum (IDLE, DWELL);
  - the default FCW_W, DWELL_W and FCW_RESET constants;
  - a sweep-descriptor struct.
- Sub-module dds_fcw_stepper is combinational. It takes fcw, step, stop and dir, and returns next plus at_stop. It is instantiated once.
- The top level holds the FSM, dwell counter, descriptor registers and output registers.

## Test plan
- Reset, then idle → fcw=16384, busy=0, done=0, phase_clr=0, cfg_ready=1.
- Up sweep, start=1000, stop=1300, step=100, dwell=2, loop=0 → fcw is 1000/1100/1200/1300, each for 3 cycles. phase_clr pulses only with 1000. busy is high 12 cycles, then done pulses once and fcw stays 1300.
- Down sweep with clamp, start=1000, stop=750, step=100, dwell=0 → fcw is 1000, 900, 800, 750 on consecutive cycles, then done.
- Overflow clamp, start=0xFFFF00, stop=0xFFFFFF, step=0x80, dwell=0 → fcw is 0xFFFF00, 0xFFFF80, 0xFFFFFF, then done; no wrap to 0.
- Loop and abort, start=0, stop=200, step=100, dwell=0, loop=1 → fcw is 0, 100, 200, 0, ..., with phase_clr at each 0. Assert abort while fcw=100 → next cycle busy=0 and fcw=100 held, with no done pulse.
- Degenerate and contention cases:
  - start=stop=500 with dwell=4 → 500 held 5 cycles, then done.
  - step=0 → same behaviour.
  - cfg_valid while busy → not accepted.
  - cfg_valid with abort in IDLE → not accepted.
  - resetn low mid-sweep → fcw=16384 next cycle.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared types and default sizing for the DDS frequency-sweep scheduler.
package dds_pkg;

    localparam int          FCW_W_DEF     = 24;
    localparam int          DWELL_W_DEF   = 16;
    localparam logic [23:0] FCW_RESET_DEF = 24'd16384;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DWELL = 1'b1
    } state_e;

    // Sweep descriptor at the default widths, as presented on the cfg_* port group.
    typedef struct packed {
        logic [FCW_W_DEF-1:0]   start_fcw;
        logic [FCW_W_DEF-1:0]   stop_fcw;
        logic [FCW_W_DEF-1:0]   step;
        logic [DWELL_W_DEF-1:0] dwell;
        logic                   loop;
    } sweep_desc_t;

endpackage

// File: rtl/dds_fcw_stepper.sv
// Combinational next-FCW calculation for one sweep step.
// The result saturates at stop in both directions and never wraps.
module dds_fcw_stepper
    import dds_pkg::*;
#(
    parameter int FCW_W = FCW_W_DEF
) (
    input  logic [FCW_W-1:0] fcw,
    input  logic [FCW_W-1:0] step,
    input  logic [FCW_W-1:0] stop,
    input  logic             dir_up,
    output logic [FCW_W-1:0] next,
    output logic             at_stop
);

    logic [FCW_W:0] sum_s;
    logic [FCW_W:0] diff_s;

    // The extra MSB is the carry (up) or borrow (down) that forces a clamp to stop.
    always_comb begin
        sum_s   = {1'b0, fcw} + {1'b0, step};
        diff_s  = {1'b0, fcw} - {1'b0, step};
        at_stop = (fcw == stop);
        if (dir_up) begin
            if (sum_s[FCW_W] || (sum_s[FCW_W-1:0] >= stop)) begin
                next = stop;
            end else begin
                next = sum_s[FCW_W-1:0];
            end
        end else begin
            if (diff_s[FCW_W] || (diff_s[FCW_W-1:0] <= stop)) begin
                next = stop;
            end else begin
                next = diff_s[FCW_W-1:0];
            end
        end
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep scheduler: accepts a sweep descriptor and steps the DDS FCW
// from start to stop, holding each value dwell+1 cycles, single-shot or looping.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int               FCW_W     = FCW_W_DEF,
    parameter int               DWELL_W   = DWELL_W_DEF,
    parameter logic [FCW_W-1:0] FCW_RESET = FCW_W'(FCW_RESET_DEF)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [FCW_W-1:0]   cfg_start_fcw,
    input  logic [FCW_W-1:0]   cfg_stop_fcw,
    input  logic [FCW_W-1:0]   cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_loop,
    input  logic               abort,
    output logic [FCW_W-1:0]   fcw,
    output logic               phase_clr,
    output logic               busy,
    output logic               done
);

    typedef struct packed {
        logic [FCW_W-1:0]   start_fcw;
        logic [FCW_W-1:0]   stop_fcw;
        logic [FCW_W-1:0]   step;
        logic [DWELL_W-1:0] dwell;
        logic               loop;
        logic               dir_up;
    } desc_t;

    state_e             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [FCW_W-1:0]   fcw_q, fcw_d;
    logic               phase_clr_q, phase_clr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    desc_t              desc_q, desc_d;

    logic [FCW_W-1:0]   next_s;
    logic               at_stop_s;
    logic               end_s;
    logic               accept_s;

    dds_fcw_stepper #(
        .FCW_W (FCW_W)
    ) u_stepper (
        .fcw     (fcw_q),
        .step    (desc_q.step),
        .stop    (desc_q.stop_fcw),
        .dir_up  (desc_q.dir_up),
        .next    (next_s),
        .at_stop (at_stop_s)
    );

    assign cfg_ready = (state_q == ST_IDLE) && !abort;
    assign accept_s  = cfg_valid && cfg_ready;
    // A zero step can never reach stop, so it ends the pass after the first value.
    assign end_s     = at_stop_s || (desc_q.step == {FCW_W{1'b0}});

    // Next-state, counter and output-register computation; abort overrides everything.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fcw_d       = fcw_q;
        phase_clr_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        desc_d      = desc_q;
        if (abort) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        desc_d.start_fcw = cfg_start_fcw;
                        desc_d.stop_fcw  = cfg_stop_fcw;
                        desc_d.step      = cfg_step;
                        desc_d.dwell     = cfg_dwell;
                        desc_d.loop      = cfg_loop;
                        desc_d.dir_up    = (cfg_stop_fcw >= cfg_start_fcw);
                        fcw_d            = cfg_start_fcw;
                        phase_clr_d      = 1'b1;
                        cnt_d            = cfg_dwell;
                        busy_d           = 1'b1;
                        state_d          = ST_DWELL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DWELL: begin
                    if (cnt_q != {DWELL_W{1'b0}}) begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end else if (end_s) begin
                        if (desc_q.loop) begin
                            fcw_d       = desc_q.start_fcw;
                            phase_clr_d = 1'b1;
                            cnt_d       = desc_q.dwell;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        fcw_d = next_s;
                        cnt_d = desc_q.dwell;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {DWELL_W{1'b0}};
            fcw_q       <= FCW_RESET;
            phase_clr_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            desc_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fcw_q       <= fcw_d;
            phase_clr_q <= phase_clr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            desc_q      <= desc_d;
        end
    end

    assign fcw       = fcw_q;
    assign phase_clr = phase_clr_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
